// File: rtl/period_meter_pkg.sv
// period_meter_pkg: FSM states and the divider threshold shared by the meter and the clock divider
package period_meter_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  function automatic logic [63:0] div_threshold(input logic [63:0] period);
    return period < 64'd2 ? '0 : (period >> 1) - 64'd1;
  endfunction
endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: slow input and measurement results of the period meter
interface period_meter_if #(parameter int WIDTH = 32);
  logic             sig_in;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] threshold_out;
  logic             valid_out;
  logic             timeout_out;
  modport master (output sig_in, input period_out, threshold_out, valid_out, timeout_out);
  modport slave (input sig_in, output period_out, threshold_out, valid_out, timeout_out);
endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: synchronizes an asynchronous input and emits a one-cycle rising-edge pulse
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      hist_q <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~hist_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures the sig_in period in clk_in cycles with averaging and stop detection
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT     = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 0
) (
  input logic           clk_in,
  input logic           rst,
  period_meter_if.slave bus
);
  localparam int                AW    = WIDTH + AVG_LOG2;
  localparam logic [WIDTH-1:0]  TMO   = WIDTH'(TIMEOUT);
  localparam logic [AVG_LOG2:0] AVG_N = (AVG_LOG2 + 1)'(2 ** AVG_LOG2);
  logic              rise;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  ctr_q, ctr_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AVG_LOG2:0] avg_q, avg_d;
  logic [WIDTH-1:0]  period_q, period_d;
  logic [WIDTH-1:0]  thr_q, thr_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst   (rst),
    .sig_i (bus.sig_in),
    .rise_o(rise)
  );
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    acc_d    = acc_q;
    avg_d    = avg_q;
    period_d = period_q;
    thr_d    = thr_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    // a full batch of samples publishes one cycle after its last rise
    if (avg_q == AVG_N) begin
      period_d = WIDTH'(acc_q >> AVG_LOG2);
      thr_d    = WIDTH'(div_threshold(64'(period_d)));
      valid_d  = 1'b1;
      tmo_d    = 1'b0;
      acc_d    = '0;
      avg_d    = '0;
    end
    if (state_q == IDLE) begin
      ctr_d   = rise ? WIDTH'(1) : '0;
      state_d = rise ? MEASURE : IDLE;
    end else if (rise) begin
      acc_d = acc_d + AW'(ctr_q);
      avg_d = avg_d + (AVG_LOG2 + 1)'(1);
      ctr_d = WIDTH'(1);
    end else if (ctr_q == TMO) begin
      tmo_d    = 1'b1;
      period_d = '0;
      thr_d    = '0;
      acc_d    = '0;
      avg_d    = '0;
      ctr_d    = '0;
      state_d  = IDLE;
    end else begin
      ctr_d = ctr_q + WIDTH'(1);
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      acc_q    <= '0;
      avg_q    <= '0;
      period_q <= '0;
      thr_q    <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
      period_q <= period_d;
      thr_q    <= thr_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end
  assign bus.period_out    = period_q;
  assign bus.threshold_out = thr_q;
  assign bus.valid_out     = valid_q;
  assign bus.timeout_out   = tmo_q;
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: event-level reference model for two meters (single and 4-period average)
module tb_period_meter;
  localparam int W = 32, TMO = 1000, S = 2;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  int errors = 0, checks = 0;
  always #5 clk_in = ~clk_in;
  period_meter_if #(.WIDTH(W)) b0 ();
  period_meter_if #(.WIDTH(W)) b2 ();
  assign b0.sig_in = sig;
  assign b2.sig_in = sig;
  period_meter #(.WIDTH(W), .TIMEOUT(TMO), .SYNC_STAGES(S), .AVG_LOG2(0)) u0 (
    .clk_in(clk_in), .rst(rst), .bus(b0));
  period_meter #(.WIDTH(W), .TIMEOUT(TMO), .SYNC_STAGES(S), .AVG_LOG2(2)) u2 (
    .clk_in(clk_in), .rst(rst), .bus(b2));

  // model: rises seen S edges late, samples are distances between rises
  bit sv [0:99999];
  int e = 0, rst_e = 0;
  bit ready = 0;
  bit armed [2], pend [2];
  int last [2], ns [2];
  longint sum [2], pval [2];
  logic [63:0] exp_p [2], exp_t [2];
  logic exp_v [2], exp_to [2];
  function automatic bit val(int i);
    return (i <= rst_e || i < 0) ? 1'b0 : sv[i];
  endfunction
  always @(posedge clk_in) begin
    e++;
    sv[e] = sig;
    for (int m = 0; m < 2; m++) begin
      int lg;
      bit r;
      lg = m == 0 ? 0 : 2;
      if (rst) begin
        rst_e = e; ready = 1;
        armed[m] = 0; pend[m] = 0; sum[m] = 0; ns[m] = 0;
        exp_p[m] = 0; exp_t[m] = 0; exp_v[m] = 0; exp_to[m] = 0;
      end else begin
        exp_v[m] = 0;
        if (pend[m]) begin
          exp_p[m] = pval[m];
          exp_t[m] = pval[m] < 2 ? 0 : pval[m] / 2 - 1;
          exp_v[m] = 1; exp_to[m] = 0; pend[m] = 0;
        end
        r = val(e - S) && !val(e - S - 1);
        if (r) begin
          if (armed[m]) begin
            sum[m] += e - last[m];
            ns[m]++;
            if (ns[m] == (1 << lg)) begin
              pend[m] = 1; pval[m] = sum[m] >> lg; sum[m] = 0; ns[m] = 0;
            end
          end
          armed[m] = 1; last[m] = e;
        end else if (armed[m] && e - last[m] == TMO) begin
          exp_p[m] = 0; exp_t[m] = 0; exp_to[m] = 1;
          armed[m] = 0; sum[m] = 0; ns[m] = 0;
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, expv);
    end
  endtask

  int nv0 = 0, nv2 = 0, nto0 = 0;
  logic [63:0] lp0 = 0, lt0 = 0, lp2 = 0, lt2 = 0;
  logic pto0 = 0;
  always @(negedge clk_in) if (ready) begin
    chk("u0.period", 64'(b0.period_out), exp_p[0]);
    chk("u0.threshold", 64'(b0.threshold_out), exp_t[0]);
    chk("u0.valid", 64'(b0.valid_out), 64'(exp_v[0]));
    chk("u0.timeout", 64'(b0.timeout_out), 64'(exp_to[0]));
    chk("u2.period", 64'(b2.period_out), exp_p[1]);
    chk("u2.threshold", 64'(b2.threshold_out), exp_t[1]);
    chk("u2.valid", 64'(b2.valid_out), 64'(exp_v[1]));
    chk("u2.timeout", 64'(b2.timeout_out), 64'(exp_to[1]));
    if (b0.valid_out === 1'b1) begin nv0++; lp0 = 64'(b0.period_out); lt0 = 64'(b0.threshold_out); end
    if (b2.valid_out === 1'b1) begin nv2++; lp2 = 64'(b2.period_out); lt2 = 64'(b2.threshold_out); end
    if (b0.timeout_out === 1'b1 && !pto0) nto0++;
    pto0 = b0.timeout_out === 1'b1;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic wave(int p, int hi, int n);
    repeat (n) begin
      sig = 1'b1; cyc(hi);
      sig = 1'b0; cyc(p - hi);
    end
  endtask
  task automatic pulse_rst();
    rst = 1'b1; cyc(1); rst = 1'b0;
  endtask

  initial begin
    int n0, n2, nt, p;
    cyc(3); rst = 1'b0;
    #1;
    chk("reset.period", 64'(b0.period_out), 0);
    chk("reset.valid", 64'(b2.valid_out), 0);
    chk("reset.timeout", 64'(b0.timeout_out), 0);
    n0 = nv0; n2 = nv2;
    wave(20, 10, 6);
    #1;
    chk("loop.count", 64'(nv0 - n0), 5);
    chk("loop.period", lp0, 20);
    chk("loop.threshold", lt0, 9);
    chk("loop.avg_count", 64'(nv2 - n2), 1);
    pulse_rst();
    n2 = nv2;
    wave(20, 10, 1); wave(22, 11, 1); wave(20, 10, 1); wave(22, 11, 1); wave(20, 10, 1);
    #1;
    chk("avg.count", 64'(nv2 - n2), 1);
    chk("avg.period", lp2, 21);
    chk("avg.threshold", lt2, 9);
    nt = nto0;
    cyc(1100);
    #1;
    chk("tmo.events", 64'(nto0 - nt), 1);
    chk("tmo.level", 64'(b0.timeout_out), 1);
    chk("tmo.period", 64'(b0.period_out), 0);
    chk("tmo.threshold", 64'(b0.threshold_out), 0);
    n0 = nv0;
    wave(20, 10, 3);
    #1;
    chk("restart.count", 64'(nv0 - n0), 2);
    chk("restart.period", lp0, 20);
    chk("restart.timeout", 64'(b0.timeout_out), 0);
    nt = nto0;
    wave(1000, 500, 3);
    #1;
    chk("bound.no_timeout", 64'(nto0 - nt), 0);
    chk("bound.period", lp0, 1000);
    chk("bound.threshold", lt0, 499);
    wave(20, 10, 3);
    cyc(4);
    pulse_rst();
    #1;
    chk("rst.period", 64'(b0.period_out), 0);
    chk("rst.threshold", 64'(b0.threshold_out), 0);
    chk("rst.valid", 64'(b0.valid_out), 0);
    chk("rst.timeout", 64'(b0.timeout_out), 0);
    cyc(5);
    n0 = nv0;
    wave(20, 10, 1);
    #1;
    chk("rst.first_rise", 64'(nv0 - n0), 0);
    wave(20, 10, 1);
    #1;
    chk("rst.second_rise", 64'(nv0 - n0), 1);
    chk("rst.period", lp0, 20);
    n0 = nv0;
    wave(2, 1, 40);
    #1;
    chk("min.count", 64'(nv0 - n0 >= 30), 1);
    chk("min.period", lp0, 2);
    chk("min.threshold", lt0, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: begin sig = 1'($urandom_range(0, 1)); pulse_rst(); end
        1: begin sig = 1'b0; cyc($urandom_range(990, 1010)); end
        default: ;
      endcase
      p = $urandom_range(2, 80);
      wave(p, $urandom_range(1, p - 1), $urandom_range(1, 8));
    end
    cyc(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
